ws2812_arbiter: RTL and testbench

//  Frame-safe owner arbiter for the single ws2812_ctrl LED-chain driver. Menu (select) and draw cfg generators are its requesters.

---
 rtl/ws2812_arbiter_if.sv | 38 +++
 rtl/ws2812_arbiter.sv | 146 ++++++++++++++
 tb/tb_ws2812_arbiter.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ws2812_arbiter_if.sv
// rtl/ws2812_arbiter_if.sv - requester, LED-driver and key signals of the WS2812 owner arbiter
interface ws2812_arbiter_if;
  logic [1:0]  mode;
  logic [4:0]  key_in;
  logic        start_sel;
  logic        start_draw;
  logic [5:0]  cfg_num_sel;
  logic [23:0] cfg_data_sel;
  logic [5:0]  cfg_num_draw;
  logic [23:0] cfg_data_draw;
  logic        cfg_start;
  logic        ws2812_start;
  logic [5:0]  cfg_num;
  logic [23:0] cfg_data;
  logic        cfg_start_sel;
  logic        cfg_start_draw;
  logic [4:0]  key_sel;
  logic [4:0]  key_draw;
  logic [1:0]  owner;
  logic        busy;
  logic        err_timeout;

  // Requesters and the LED driver side.
  modport master (
    output mode, key_in, start_sel, start_draw,
    output cfg_num_sel, cfg_data_sel, cfg_num_draw, cfg_data_draw, cfg_start,
    input  ws2812_start, cfg_num, cfg_data, cfg_start_sel, cfg_start_draw,
    input  key_sel, key_draw, owner, busy, err_timeout
  );

  // The arbiter itself.
  modport slave (
    input  mode, key_in, start_sel, start_draw,
    input  cfg_num_sel, cfg_data_sel, cfg_num_draw, cfg_data_draw, cfg_start,
    output ws2812_start, cfg_num, cfg_data, cfg_start_sel, cfg_start_draw,
    output key_sel, key_draw, owner, busy, err_timeout
  );
endinterface

// File: rtl/ws2812_arbiter.sv
// rtl/ws2812_arbiter.sv - frame-safe owner arbiter in front of a single ws2812_ctrl driver
module ws2812_arbiter #(
  parameter int LED_NUM     = 64,
  parameter int GAP_CYC     = 16500,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic           sys_clk,
  input  logic           sys_rst_n,
  ws2812_arbiter_if.slave bus
);

  localparam int TMAX = (GAP_CYC > TIMEOUT_CYC) ? GAP_CYC : TIMEOUT_CYC;
  localparam int TW   = (TMAX > 2) ? $clog2(TMAX) : 1;

  localparam logic [1:0]    OWN_SEL  = 2'b00;
  localparam logic [1:0]    OWN_DRAW = 2'b10;
  localparam logic [1:0]    OWN_NONE = 2'b11;
  localparam logic [5:0]    LAST_LED = 6'(LED_NUM - 1);
  localparam logic [TW-1:0] GAP_LAST = TW'(GAP_CYC - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_GAP} state_t;

  state_t        state_q, state_d;
  logic [1:0]    owner_q, owner_d;
  logic          pend_sel_q, pend_sel_d;
  logic          pend_draw_q, pend_draw_d;
  logic [5:0]    led_cnt_q, led_cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          start_q, start_d;
  logic          err_q, err_d;
  logic [4:0]    key_sel_q, key_draw_q;

  logic       owner_is_sel;
  logic       owner_is_draw;
  logic [1:0] mode_norm;
  logic       owner_pend;

  // Unknown mode codes collapse to "no owner" so owner only ever holds 00/10/11.
  assign mode_norm     = (bus.mode == OWN_SEL || bus.mode == OWN_DRAW) ? bus.mode : OWN_NONE;
  assign owner_is_sel  = (owner_q == OWN_SEL);
  assign owner_is_draw = (owner_q == OWN_DRAW);
  assign owner_pend    = (owner_is_sel & pend_sel_q) | (owner_is_draw & pend_draw_q);

  // State, owner, pending requests, LED counter and shared timer.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_NONE;
      pend_sel_q  <= 1'b0;
      pend_draw_q <= 1'b0;
      led_cnt_q   <= '0;
      timer_q     <= '0;
      start_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      pend_sel_q  <= pend_sel_d;
      pend_draw_q <= pend_draw_d;
      led_cnt_q   <= led_cnt_d;
      timer_q     <= timer_d;
      start_q     <= start_d;
      err_q       <= err_d;
    end
  end

  // Frame sequencing: owner changes only in IDLE, watchdog and latch gap share one timer.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    pend_sel_d  = pend_sel_q;
    pend_draw_d = pend_draw_q;
    led_cnt_d   = led_cnt_q;
    timer_d     = timer_q;
    start_d     = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mode_norm != owner_q) begin
          // Switch owner; a request left behind by the old owner is dropped.
          owner_d = mode_norm;
          if (owner_is_sel)  pend_sel_d  = 1'b0;
          if (owner_is_draw) pend_draw_d = 1'b0;
        end else if (owner_pend) begin
          start_d   = 1'b1;
          led_cnt_d = '0;
          timer_d   = '0;
          state_d   = ST_BUSY;
          if (owner_is_sel) pend_sel_d  = 1'b0;
          else              pend_draw_d = 1'b0;
        end
      end
      ST_BUSY: begin
        if (bus.cfg_start) begin
          led_cnt_d = led_cnt_q + 6'd1;
          timer_d   = '0;
          if (led_cnt_q == LAST_LED) state_d = ST_GAP;
        end else if (timer_q == TMO_LAST) begin
          err_d   = 1'b1;
          timer_d = '0;
          state_d = ST_GAP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (timer_q == GAP_LAST) begin
          timer_d = '0;
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Requests are latched in every state; repeated pulses merge into one.
    if (bus.start_sel)  pend_sel_d  = 1'b1;
    if (bus.start_draw) pend_draw_d = 1'b1;
  end

  // Keys follow the owner registered at the sampling edge.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      key_sel_q  <= '0;
      key_draw_q <= '0;
    end else begin
      key_sel_q  <= owner_is_sel  ? bus.key_in : 5'd0;
      key_draw_q <= owner_is_draw ? bus.key_in : 5'd0;
    end
  end

  assign bus.ws2812_start   = start_q;
  assign bus.err_timeout    = err_q;
  assign bus.owner          = owner_q;
  assign bus.busy           = (state_q != ST_IDLE);
  assign bus.cfg_start_sel  = bus.cfg_start & (state_q == ST_BUSY) & owner_is_sel;
  assign bus.cfg_start_draw = bus.cfg_start & (state_q == ST_BUSY) & owner_is_draw;
  assign bus.cfg_num        = owner_is_sel  ? bus.cfg_num_sel  :
                              owner_is_draw ? bus.cfg_num_draw : 6'd0;
  assign bus.cfg_data       = owner_is_sel  ? bus.cfg_data_sel  :
                              owner_is_draw ? bus.cfg_data_draw : 24'd0;
  assign bus.key_sel        = key_sel_q;
  assign bus.key_draw       = key_draw_q;

endmodule

// File: tb/tb_ws2812_arbiter.sv
// tb/tb_ws2812_arbiter.sv - scoreboard bench for ws2812_arbiter
module tb_ws2812_arbiter;
  localparam int LED_NUM     = 64;
  localparam int GAP_CYC     = 40;
  localparam int TIMEOUT_CYC = 200;
  localparam logic [23:0] DATA_SEL  = 24'h112233;
  localparam logic [23:0] DATA_DRAW = 24'hAABBCC;

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  ws2812_arbiter_if bus();

  ws2812_arbiter #(
    .LED_NUM(LED_NUM),
    .GAP_CYC(GAP_CYC),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus(bus)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef enum int {EV_START, EV_FEND, EV_TMO, EV_KEY} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       cyc;
    int       a;
    int       b;
  } ev_t;

  ev_t expq[$];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void push_exp(ev_kind_t k, int c, int a, int b);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    e.a    = a;
    e.b    = b;
    expq.push_back(e);
  endfunction

  task automatic observed(input ev_kind_t k, input int c, input int a, input int b);
    ev_t e;
    if (expq.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL unexpected_event: got kind %0d at cycle %0d (a=%0h b=%0h), expected none", k, c, a, b);
    end else begin
      e = expq.pop_front();
      cmp($sformatf("ev%0d.kind", e.kind), k, e.kind);
      cmp($sformatf("ev%0d.cycle", e.kind), c, e.cyc);
      cmp($sformatf("ev%0d.a", e.kind), a, e.a);
      cmp($sformatf("ev%0d.b", e.kind), b, e.b);
    end
  endtask

  // Monitor: turns DUT output activity into events and scores them against the queue.
  int cnt_sel = 0;
  int cnt_draw = 0;
  bit prev_busy = 1'b0;
  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      prev_busy = 1'b0;
    end else begin
      if (bus.ws2812_start) begin
        observed(EV_START, cyc, int'(bus.owner), int'(bus.cfg_data));
        cnt_sel  = 0;
        cnt_draw = 0;
      end
      if (bus.cfg_start_sel)  cnt_sel++;
      if (bus.cfg_start_draw) cnt_draw++;
      if (bus.err_timeout) observed(EV_TMO, cyc, 0, 0);
      if (prev_busy && !bus.busy) observed(EV_FEND, cyc, cnt_sel, cnt_draw);
      if (bus.key_sel != 5'd0 || bus.key_draw != 5'd0)
        observed(EV_KEY, cyc, int'(bus.key_sel), int'(bus.key_draw));
      prev_busy = bus.busy;
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic run_leds(input int n, output int last);
    last = cyc;
    for (int i = 0; i < n; i++) begin
      tick();
      bus.cfg_start = 1'b1;
      last = cyc;
      tick();
      bus.cfg_start = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "time limit");
  end

  initial begin
    int n, last, e, c, k;
    bus.mode          = 2'b00;
    bus.key_in        = 5'd0;
    bus.start_sel     = 1'b0;
    bus.start_draw    = 1'b0;
    bus.cfg_num_sel   = 6'd5;
    bus.cfg_data_sel  = DATA_SEL;
    bus.cfg_num_draw  = 6'd9;
    bus.cfg_data_draw = DATA_DRAW;
    bus.cfg_start     = 1'b0;

    // Reset values.
    repeat (3) tick();
    cmp("rst.owner", bus.owner, 2'b11);
    cmp("rst.busy", bus.busy, 0);
    cmp("rst.cfg_data", bus.cfg_data, 0);
    cmp("rst.cfg_num", bus.cfg_num, 0);
    cmp("rst.ws2812_start", bus.ws2812_start, 0);
    sys_rst_n = 1'b1;
    tick();
    cmp("post_rst.owner", bus.owner, 2'b00);
    cmp("post_rst.cfg_data", bus.cfg_data, DATA_SEL);

    // Select frame: start at N+2, 64 forwarded cfg_start, busy low GAP_CYC after the last one.
    tick();
    bus.start_sel = 1'b1;
    n = cyc;
    push_exp(EV_START, n + 2, 0, DATA_SEL);
    tick();
    bus.start_sel = 1'b0;
    wait_until(n + 4);
    run_leds(LED_NUM, last);
    push_exp(EV_FEND, last + GAP_CYC + 1, LED_NUM, 0);
    wait_until(last + GAP_CYC + 4);

    // Draw request and mode change mid select frame: owner held, draw frame right after the gap.
    tick();
    bus.start_sel = 1'b1;
    n = cyc;
    push_exp(EV_START, n + 2, 0, DATA_SEL);
    tick();
    bus.start_sel = 1'b0;
    wait_until(n + 4);
    run_leds(30, last);
    tick();
    bus.start_draw = 1'b1;
    tick();
    bus.start_draw = 1'b0;
    run_leds(10, last);
    tick();
    bus.mode = 2'b10;
    tick();
    cmp("frame.owner_hold", bus.owner, 2'b00);
    run_leds(LED_NUM - 40, last);
    e = last + GAP_CYC + 1;
    push_exp(EV_FEND, e, LED_NUM, 0);
    push_exp(EV_START, e + 2, 2, DATA_DRAW);
    wait_until(e + 4);
    cmp("draw.cfg_num", bus.cfg_num, 6'd9);
    run_leds(LED_NUM, last);
    push_exp(EV_FEND, last + GAP_CYC + 1, 0, LED_NUM);
    wait_until(last + GAP_CYC + 4);

    // Key routing: draw owner, then no owner, then select owner.
    tick();
    bus.key_in = 5'b00100;
    k = cyc;
    push_exp(EV_KEY, k + 1, 0, 5'b00100);
    tick();
    bus.key_in = 5'd0;
    tick();
    bus.mode = 2'b01;
    tick();
    bus.key_in = 5'b00100;
    tick();
    cmp("none.owner", bus.owner, 2'b11);
    cmp("none.key_sel", bus.key_sel, 0);
    cmp("none.key_draw", bus.key_draw, 0);
    cmp("none.cfg_data", bus.cfg_data, 0);
    bus.key_in = 5'd0;
    bus.mode = 2'b00;
    repeat (2) tick();
    bus.key_in = 5'b10001;
    k = cyc;
    push_exp(EV_KEY, k + 1, 5'b10001, 0);
    tick();
    bus.key_in = 5'd0;
    repeat (2) tick();

    // Watchdog: 10 LEDs then silence; a start queued during the frame is served after the gap.
    bus.start_sel = 1'b1;
    n = cyc;
    push_exp(EV_START, n + 2, 0, DATA_SEL);
    tick();
    bus.start_sel = 1'b0;
    wait_until(n + 4);
    run_leds(10, last);
    c = last;
    tick();
    bus.start_sel = 1'b1;
    tick();
    bus.start_sel = 1'b0;
    e = c + TIMEOUT_CYC + 1 + GAP_CYC;
    push_exp(EV_TMO, c + TIMEOUT_CYC + 1, 0, 0);
    push_exp(EV_FEND, e, 10, 0);
    push_exp(EV_START, e + 1, 0, DATA_SEL);
    wait_until(e + 4);
    run_leds(5, last);

    // Reset in the middle of BUSY.
    sys_rst_n = 1'b0;
    bus.cfg_start = 1'b1;
    tick();
    cmp("midrst.owner", bus.owner, 2'b11);
    cmp("midrst.busy", bus.busy, 0);
    cmp("midrst.cfg_start_sel", bus.cfg_start_sel, 0);
    cmp("midrst.cfg_data", bus.cfg_data, 0);
    bus.cfg_start = 1'b0;
    sys_rst_n = 1'b1;
    tick();
    cmp("midrst.readopt", bus.owner, 2'b00);
    repeat (5) tick();

    cmp("queue_drained", expq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
